// File: rtl/ttseq_pkg.sv
// ttseq_pkg: shared state encoding and limits for the truth-table sequencer
package ttseq_pkg;
  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;
  localparam int MAX_INPUTS = 4;
  localparam int MAX_SETTLE = 15;
endpackage

// File: rtl/ttseq_settle_cnt.sv
// ttseq_settle_cnt: loadable down-counter; expire is high on the last enabled cycle of a SETTLE-cycle hold
module ttseq_settle_cnt
  import ttseq_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);
  localparam int W = $clog2(MAX_SETTLE + 1);
  localparam logic [W-1:0] INIT = W'(SETTLE - 1);
  logic [W-1:0] cnt;
  assign expire = en && cnt == '0;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= INIT;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  end
endmodule

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: sweeps all input vectors of a small gate and checks it against EXPECT.
// Define TTSEQ_FIRST_FAIL_EN to add first_fail / first_fail_vld capture of the first mismatching vector.
module truth_table_sequencer
  import ttseq_pkg::*;
#(
  parameter int N_INPUTS = 2,
  parameter logic [2**N_INPUTS-1:0] EXPECT = 4'b1000,
  parameter int SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [N_INPUTS-1:0] vec,
  input  logic                dut_o,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_INPUTS:0]   err_count
`ifdef TTSEQ_FIRST_FAIL_EN
  ,
  output logic [N_INPUTS-1:0] first_fail,
  output logic                first_fail_vld
`endif
);
  localparam logic [N_INPUTS-1:0] LAST = N_INPUTS'(2**N_INPUTS - 1);
  localparam logic [N_INPUTS:0] SAT = (N_INPUTS+1)'(2**N_INPUTS);
  state_t state, state_n;
  logic [N_INPUTS-1:0] vec_n;
  logic [N_INPUTS:0] err_n;
  logic busy_n, done_n, pass_n, load, expire, miss;
  assign miss = dut_o != EXPECT[vec];
`ifdef TTSEQ_FIRST_FAIL_EN
  logic [N_INPUTS-1:0] first_fail_n;
  logic first_fail_vld_n;
`endif
  ttseq_settle_cnt #(.SETTLE(SETTLE)) u_settle (
    .clk(clk),
    .rst(rst),
    .load(load),
    .en(state == APPLY),
    .expire(expire)
  );
  always_comb begin
    state_n = state;
    vec_n = vec;
    err_n = err_count;
    busy_n = busy;
    done_n = done;
    pass_n = pass;
    load = 1'b0;
`ifdef TTSEQ_FIRST_FAIL_EN
    first_fail_n = first_fail;
    first_fail_vld_n = first_fail_vld;
`endif
    case (state)
      IDLE, DONE: if (start) begin
        state_n = APPLY;
        vec_n = '0;
        err_n = '0;
        busy_n = 1'b1;
        done_n = 1'b0;
        pass_n = 1'b0;
        load = 1'b1;
`ifdef TTSEQ_FIRST_FAIL_EN
        first_fail_n = '0;
        first_fail_vld_n = 1'b0;
`endif
      end
      APPLY: state_n = expire ? CHECK : APPLY;
      CHECK: begin
        err_n = (miss && err_count != SAT) ? err_count + 1'b1 : err_count;
`ifdef TTSEQ_FIRST_FAIL_EN
        if (miss && !first_fail_vld) begin
          first_fail_n = vec;
          first_fail_vld_n = 1'b1;
        end
`endif
        if (vec == LAST) begin
          state_n = DONE;
          busy_n = 1'b0;
          done_n = 1'b1;
          pass_n = err_n == '0;
        end else begin
          state_n = APPLY;
          vec_n = vec + 1'b1;
          load = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      vec <= '0;
      err_count <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
`ifdef TTSEQ_FIRST_FAIL_EN
      first_fail <= '0;
      first_fail_vld <= 1'b0;
`endif
    end else begin
      state <= state_n;
      vec <= vec_n;
      err_count <= err_n;
      busy <= busy_n;
      done <= done_n;
      pass <= pass_n;
`ifdef TTSEQ_FIRST_FAIL_EN
      first_fail <= first_fail_n;
      first_fail_vld <= first_fail_vld_n;
`endif
    end
  end
endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb_truth_table_sequencer: directed checks of the default AND sweep plus a 1-input inverter instance
module tb_truth_table_sequencer;
  logic clk = 1'b0;
  logic rst, start, start2;
  logic [1:0] mode;
  logic [1:0] vec;
  logic [0:0] vec2;
  logic dut_o, dut_o2, busy, done, pass, busy2, done2, pass2;
  logic [2:0] err_count;
  logic [1:0] err_count2;
  int errors = 0;
  int checks = 0;
`ifdef TTSEQ_FIRST_FAIL_EN
  logic [1:0] first_fail;
  logic first_fail_vld;
  logic [0:0] first_fail2;
  logic first_fail_vld2;
`endif

  always #5 clk = ~clk;

  // gate models: 0 = AND, 1 = NAND, 2 = stuck at 0
  assign dut_o = mode == 2'd0 ? (vec[0] & vec[1]) : mode == 2'd1 ? ~(vec[0] & vec[1]) : 1'b0;
  assign dut_o2 = ~vec2[0];

  truth_table_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .vec(vec), .dut_o(dut_o),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count)
`ifdef TTSEQ_FIRST_FAIL_EN
    , .first_fail(first_fail), .first_fail_vld(first_fail_vld)
`endif
  );

  truth_table_sequencer #(.N_INPUTS(1), .EXPECT(2'b01), .SETTLE(3)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .vec(vec2), .dut_o(dut_o2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2)
`ifdef TTSEQ_FIRST_FAIL_EN
    , .first_fail(first_fail2), .first_fail_vld(first_fail_vld2)
`endif
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // returns 1 ns after edge k, where start was sampled
  task automatic pulse_start;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; mode = 2'd0;
    step(2);
    rst = 1'b0;
    checks++;
    if ({vec, busy, done, pass, err_count} !== 8'b0) begin
      errors++;
      $display("FAIL reset: vec=%0d busy=%0b done=%0b pass=%0b err=%0d, need all 0", vec, busy, done, pass, err_count);
    end
    checks++;
    if ({vec2, busy2, done2, pass2, err_count2} !== 6'b0) begin
      errors++;
      $display("FAIL reset2: vec=%0d busy=%0b done=%0b pass=%0b err=%0d, need all 0", vec2, busy2, done2, pass2, err_count2);
    end
  endtask

  task automatic test_and_pass;
    mode = 2'd0;
    pulse_start;
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (vec !== 2'(j / 2) || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL and_seq k+%0d: vec=%0d busy=%0b done=%0b, need vec=%0d busy=1 done=0", j, vec, busy, done, j / 2);
      end
      step(1);
    end
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || err_count !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL and_end: done=%0b pass=%0b err=%0d busy=%0b, need 1 1 0 0", done, pass, err_count, busy);
    end
  endtask

  task automatic test_nand;
    mode = 2'd1;
    pulse_start;
    step(7);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL nand_k7: done=%0b busy=%0b, need 0 1", done, busy);
    end
    step(1);
    checks++;
    if (done !== 1'b1 || pass !== 1'b0 || err_count !== 3'd4) begin
      errors++;
      $display("FAIL nand_end: done=%0b pass=%0b err=%0d, need 1 0 4", done, pass, err_count);
    end
`ifdef TTSEQ_FIRST_FAIL_EN
    checks++;
    if (first_fail !== 2'd0 || first_fail_vld !== 1'b1) begin
      errors++;
      $display("FAIL nand_ff: first_fail=%0d vld=%0b, need 0 1", first_fail, first_fail_vld);
    end
`endif
  endtask

  task automatic test_stuck0;
    mode = 2'd2;
    pulse_start;
    step(8);
    checks++;
    if (done !== 1'b1 || pass !== 1'b0 || err_count !== 3'd1) begin
      errors++;
      $display("FAIL stuck0_end: done=%0b pass=%0b err=%0d, need 1 0 1", done, pass, err_count);
    end
`ifdef TTSEQ_FIRST_FAIL_EN
    checks++;
    if (first_fail !== 2'd3 || first_fail_vld !== 1'b1) begin
      errors++;
      $display("FAIL stuck0_ff: first_fail=%0d vld=%0b, need 3 1", first_fail, first_fail_vld);
    end
`endif
  endtask

  task automatic test_restart_ignored;
    mode = 2'd1;
    pulse_start;
    step(2);
    start = 1'b1;
    step(1);
    start = 1'b0;
    for (int j = 3; j < 8; j++) begin
      checks++;
      if (vec !== 2'(j / 2) || busy !== 1'b1) begin
        errors++;
        $display("FAIL ignore_seq k+%0d: vec=%0d busy=%0b, need vec=%0d busy=1", j, vec, busy, j / 2);
      end
      step(1);
    end
    checks++;
    if (done !== 1'b1 || err_count !== 3'd4) begin
      errors++;
      $display("FAIL ignore_end: done=%0b err=%0d, need 1 4", done, err_count);
    end
    mode = 2'd0;
    pulse_start;
    checks++;
    if (done !== 1'b0 || err_count !== 3'd0 || busy !== 1'b1 || vec !== 2'd0) begin
      errors++;
      $display("FAIL restart_clear: done=%0b err=%0d busy=%0b vec=%0d, need 0 0 1 0", done, err_count, busy, vec);
    end
    step(7);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL restart_k7: done=%0b, need 0", done);
    end
    step(1);
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || err_count !== 3'd0) begin
      errors++;
      $display("FAIL restart_end: done=%0b pass=%0b err=%0d, need 1 1 0", done, pass, err_count);
    end
  endtask

  task automatic test_mid_reset;
    mode = 2'd1;
    pulse_start;
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++;
    if ({vec, busy, done, pass, err_count} !== 8'b0) begin
      errors++;
      $display("FAIL midrst: vec=%0d busy=%0b done=%0b pass=%0b err=%0d, need all 0", vec, busy, done, pass, err_count);
    end
`ifdef TTSEQ_FIRST_FAIL_EN
    checks++;
    if (first_fail_vld !== 1'b0 || first_fail !== 2'd0) begin
      errors++;
      $display("FAIL midrst_ff: first_fail=%0d vld=%0b, need 0 0", first_fail, first_fail_vld);
    end
`endif
    step(12);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || vec !== 2'd0) begin
      errors++;
      $display("FAIL midrst_idle: done=%0b busy=%0b vec=%0d, need 0 0 0", done, busy, vec);
    end
  endtask

  task automatic test_inverter;
    start2 = 1'b1;
    step(1);
    start2 = 1'b0;
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (vec2 !== 1'(j / 4) || busy2 !== 1'b1 || done2 !== 1'b0) begin
        errors++;
        $display("FAIL inv_seq k+%0d: vec=%0d busy=%0b done=%0b, need vec=%0d busy=1 done=0", j, vec2, busy2, done2, j / 4);
      end
      step(1);
    end
    checks++;
    if (done2 !== 1'b1 || pass2 !== 1'b1 || err_count2 !== 2'd0 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL inv_end: done=%0b pass=%0b err=%0d busy=%0b, need 1 1 0 0", done2, pass2, err_count2, busy2);
    end
  endtask

  initial begin
    test_reset;
    test_and_pass;
    test_nand;
    test_stuck0;
    test_restart_ignored;
    test_mid_reset;
    test_inverter;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/truth_table_sequencer.md
# truth_table_sequencer

- Self-checking stimulus stage that sits directly upstream of a small combinational gate under test, such as the 2-input behavioural AND.
- Walks every input combination in ascending binary order and holds each for a programmable settle time.
- Samples the gate output and compares it with an expected truth table given as a parameter.
- Reports a mismatch count and a pass flag, so gate checks run in hardware or in a bench without hand-written vectors.

## Interface
Parameters:
- N_INPUTS, 2: number of gate inputs driven; legal range 1..4.
- EXPECT, 4'b1000: expected truth table, width 2**N_INPUTS; bit i is the expected output for input vector i. The default is 2-input AND.
- SETTLE, 1: cycles each vector is held before sampling; legal range 1..15.

Ports:
- clk  in  1  single clock; all logic rises on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; honoured only when not busy.
- vec  out  N_INPUTS  vector driven to the gate; vec[0] is input a and vec[1] is input b.
- dut_o  in  1  gate output being checked.
- busy  out  1  high while a sweep is running.
- done  out  1  high once a sweep finishes; stays high until the next accepted start or until rst.
- pass  out  1  high together with done when err_count == 0.
- err_count  out  N_INPUTS+1  number of mismatching vectors in the current or last sweep.

## Operation
FSM states are IDLE, APPLY, CHECK and DONE.

Reset values:
- state = IDLE.
- vec = 0.
- busy = 0, done = 0, pass = 0.
- err_count = 0.
- settle counter = 0.

Transitions:
- IDLE or DONE, with start=1: go to APPLY. Set vec=0, clear err_count, done and pass, and set busy=1.
- APPLY: the settle counter counts SETTLE cycles, then the FSM goes to CHECK.
- CHECK, one cycle: compare dut_o with EXPECT[vec]. On inequality, increment err_count, which saturates at 2**N_INPUTS.
  - If vec == 2**N_INPUTS-1: go to DONE. Set busy=0, done=1, and pass = (final err_count == 0). The final count includes the current comparison.
  - Otherwise: vec increments by 1 and the FSM goes to APPLY.

Rules:
- vec stays constant through APPLY and CHECK of the same vector. It changes only on the CHECK→APPLY edge.
- start while busy is ignored and has no side effects.
- start in DONE restarts the sweep.
- rst at any time, including mid-sweep, returns every output to its reset value on the next edge. No partial result is kept.
- vec never wraps past 2**N_INPUTS-1 within a sweep.

## Timing
- Each vector takes SETTLE+1 cycles. Sweep length L = 2**N_INPUTS × (SETTLE+1) cycles.
- start is sampled at edge k:
  - busy is high from edge k to edge k+L.
  - done, pass and the final err_count are valid from edge k+L.
- Defaults (N_INPUTS=2, SETTLE=1): L = 8.
- The comparison uses dut_o as sampled at the edge that ends the CHECK cycle. dut_o must be stable SETTLE cycles after vec changes.
- No combinational path exists from dut_o or start to any output.

## Configuration
- Macro: TTSEQ_FIRST_FAIL_EN.
- Defined: two extra outputs are added.
  - first_fail (N_INPUTS bits) captures vec at the first mismatch of a sweep.
  - first_fail_vld (1 bit) is set at the same time.
  - Both clear to 0 on rst or on an accepted start.
  - Later mismatches in the same sweep do not overwrite them.
- Undefined: neither port nor the capture register exists, and all other behaviour is identical.

## Structure
- Package ttseq_pkg holds:
  - the state typedef (IDLE, APPLY, CHECK, DONE; 2-bit encoding);
  - the constants MAX_INPUTS=4 and MAX_SETTLE=15.
- One sub-module, ttseq_settle_cnt: a loadable down-counter with an expire pulse, instantiated once for the APPLY hold.
- The FSM, vector register, error counter and the optional first-fail capture live in the top module.

## Test plan
All scenarios use the defaults unless stated.
1. Correct AND gate connected, start at edge k:
   - vec steps 0,1,2,3, each held 2 cycles;
   - done=1 and pass=1 at k+8, err_count=0, busy low at k+8.
2. NAND gate connected:
   - err_count=4, pass=0, done=1 at k+8;
   - with TTSEQ_FIRST_FAIL_EN: first_fail=0, first_fail_vld=1.
3. dut_o stuck at 0:
   - err_count=1, pass=0;
   - with the macro: first_fail=3.
4. start re-pulsed at k+3 during the sweep:
   - ignored; done still at k+8 and vec sequence unchanged.
   - Then start again in DONE: err_count and done clear next edge, and a new sweep finishes 8 cycles later.
5. rst asserted at k+5:
   - next edge gives vec=0, busy=0, done=0, pass=0, err_count=0, state IDLE;
   - no done follows without a new start.
6. SETTLE=3, N_INPUTS=1, EXPECT=2'b01 (inverter), inverter connected:
   - vec 0 then 1, each held 4 cycles;
   - done at k+8 with pass=1.
